// File: rtl/signed_sum_accumulator_if.sv
// Handshake bus for the signed frame accumulator: sum stream in, frame result out.
interface signed_sum_accumulator_if #(
    parameter int unsigned ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_sum;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_sat;

    // Upstream/downstream environment side
    modport master (
        output in_valid,
        output in_sum,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_acc,
        input  out_sat
    );

    // Accumulator side
    modport slave (
        input  in_valid,
        input  in_sum,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_acc,
        output out_sat
    );
endinterface

// File: rtl/signed_sum_accumulator.sv
// Accumulates N_SAMPLES signed 5-bit sums per frame with saturating add,
// then holds the frame total until the downstream handshake.
module signed_sum_accumulator #(
    parameter int unsigned N_SAMPLES = 4,
    parameter int unsigned ACC_W     = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    signed_sum_accumulator_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(N_SAMPLES + 1);
    localparam int unsigned EXT_W = ACC_W - 4;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic [ACC_W:0]   sum_wide_c;
    logic             ovf_c;

    // Saturating add of the sign-extended input sum to the running total
    always_comb begin
        sum_wide_c = {acc_q[ACC_W-1], acc_q} + {{EXT_W{bus.in_sum[4]}}, bus.in_sum};
        ovf_c      = sum_wide_c[ACC_W] ^ sum_wide_c[ACC_W-1];
        acc_d      = sum_wide_c[ACC_W-1:0];
        if (ovf_c) begin
            acc_d = sum_wide_c[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // Frame FSM with accumulator, sample counter and sticky saturation flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else if (clr) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_q | ovf_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q <= ACCUM;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ACCUM;
                end
            endcase
        end
    end

    // Handshake flags and result are pure decodes of registered state
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_acc   = (state_q == HOLD) ? acc_q : '0;
    assign bus.out_sat   = (state_q == HOLD) ? sat_q : 1'b0;

endmodule

// File: tb/tb_signed_sum_accumulator.sv
// Directed bench for signed_sum_accumulator: three configurations side by side.
module tb_signed_sum_accumulator;
    logic clk;
    logic rstn;
    logic clr8;
    logic clr6;
    logic clr1;

    int passed;
    int total;

    signed_sum_accumulator_if #(.ACC_W(8)) b8 ();
    signed_sum_accumulator_if #(.ACC_W(6)) b6 ();
    signed_sum_accumulator_if #(.ACC_W(8)) b1 ();

    signed_sum_accumulator #(.N_SAMPLES(4), .ACC_W(8)) u8 (
        .clk(clk), .rstn(rstn), .clr(clr8), .bus(b8.slave)
    );
    signed_sum_accumulator #(.N_SAMPLES(4), .ACC_W(6)) u6 (
        .clk(clk), .rstn(rstn), .clr(clr6), .bus(b6.slave)
    );
    signed_sum_accumulator #(.N_SAMPLES(1), .ACC_W(8)) u1 (
        .clk(clk), .rstn(rstn), .clr(clr1), .bus(b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sum to the 8-bit N=4 instance for one clock
    task automatic push8(input int v);
        b8.in_valid = 1'b1;
        b8.in_sum   = 5'(v);
        tick();
        b8.in_valid = 1'b0;
    endtask

    task automatic push6(input int v);
        b6.in_valid = 1'b1;
        b6.in_sum   = 5'(v);
        tick();
        b6.in_valid = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rstn = 1'b0;
        clr8 = 1'b0; clr6 = 1'b0; clr1 = 1'b0;
        b8.in_valid = 1'b0; b8.in_sum = '0; b8.out_ready = 1'b0;
        b6.in_valid = 1'b0; b6.in_sum = '0; b6.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_sum = '0; b1.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(b8.in_ready), 1);
        chk("rst_out_valid", 32'(b8.out_valid), 0);
        chk("rst_out_acc", 32'($signed(b8.out_acc)), 0);
        chk("rst_out_sat", 32'(b8.out_sat), 0);
        rstn = 1'b1;

        // Basic frame 3, -2, 7, 1 -> 9
        b8.out_ready = 1'b1;
        push8(3); push8(-2); push8(7);
        chk("basic_not_yet_valid", 32'(b8.out_valid), 0);
        push8(1);
        chk("basic_out_valid", 32'(b8.out_valid), 1);
        chk("basic_in_ready_low", 32'(b8.in_ready), 0);
        chk("basic_out_acc", 32'($signed(b8.out_acc)), 9);
        chk("basic_out_sat", 32'(b8.out_sat), 0);
        tick();
        chk("basic_in_ready_back", 32'(b8.in_ready), 1);
        chk("basic_accum_acc_zero", 32'($signed(b8.out_acc)), 0);

        // Backpressure: 1,2,3,4 -> 10 held while in_valid stays high
        b8.out_ready = 1'b0;
        push8(1); push8(2); push8(3); push8(4);
        b8.in_valid = 1'b1;
        b8.in_sum   = 5'(5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_in_ready", 32'(b8.in_ready), 0);
            chk("bp_out_acc", 32'($signed(b8.out_acc)), 10);
        end
        b8.out_ready = 1'b1;
        tick();
        chk("bp_released", 32'(b8.out_valid), 0);
        b8.out_ready = 1'b0;
        push8(5); push8(5); push8(5); push8(5);
        chk("bp_next_frame", 32'($signed(b8.out_acc)), 20);
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;

        // clr after two sums, coincident with a valid sum that must be dropped
        push8(6); push8(6);
        clr8 = 1'b1;
        push8(6);
        clr8 = 1'b0;
        push8(1); push8(1); push8(1);
        chk("clr_not_early", 32'(b8.out_valid), 0);
        push8(2);
        chk("clr_frame_valid", 32'(b8.out_valid), 1);
        chk("clr_frame_acc", 32'($signed(b8.out_acc)), 5);
        b8.out_ready = 1'b1;
        tick();
        b8.out_ready = 1'b0;

        // Positive saturation on ACC_W=6 then a fresh frame
        b6.out_ready = 1'b0;
        push6(14); push6(14); push6(14); push6(14);
        chk("satp_out_acc", 32'($signed(b6.out_acc)), 31);
        chk("satp_out_sat", 32'(b6.out_sat), 1);
        b6.out_ready = 1'b1;
        tick();
        b6.out_ready = 1'b0;
        chk("satp_cleared_sat", 32'(b6.out_sat), 0);
        push6(14);
        push6(-14);
        push6(1); push6(2);
        chk("fresh_from_zero_acc", 32'($signed(b6.out_acc)), 3);
        chk("fresh_from_zero_sat", 32'(b6.out_sat), 0);
        b6.out_ready = 1'b1;
        tick();
        b6.out_ready = 1'b0;
        push6(14); push6(14); push6(14); push6(14);
        chk("satp2_out_acc", 32'($signed(b6.out_acc)), 31);
        chk("satp2_out_sat", 32'(b6.out_sat), 1);
        b6.out_ready = 1'b1;
        tick();
        b6.out_ready = 1'b0;

        // Negative clamp then recovery: -16,-16,-16,+14 -> -18
        push6(-16); push6(-16); push6(-16); push6(14);
        chk("satn_out_acc", 32'($signed(b6.out_acc)), -18);
        chk("satn_out_sat", 32'(b6.out_sat), 1);
        b6.out_ready = 1'b1;
        tick();
        b6.out_ready = 1'b0;

        // N_SAMPLES=1: single sum frame, then back-to-back stream
        b1.out_ready = 1'b0;
        b1.in_valid  = 1'b1;
        b1.in_sum    = 5'(-5);
        tick();
        b1.in_valid  = 1'b0;
        chk("n1_out_valid", 32'(b1.out_valid), 1);
        chk("n1_out_acc", 32'($signed(b1.out_acc)), -5);
        chk("n1_out_acc_raw", 32'(b1.out_acc), 32'hFB);
        b1.out_ready = 1'b1;
        b1.in_valid  = 1'b1;
        b1.in_sum    = 5'(4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("n1_b2b_gap", 32'(b1.out_valid), 0);
            tick();
            chk("n1_b2b_valid", 32'(b1.out_valid), 1);
            chk("n1_b2b_acc", 32'($signed(b1.out_acc)), 4);
        end
        b1.in_valid  = 1'b0;
        tick();

        // Reset asserted during HOLD drops the pending result at once
        push8(2); push8(2); push8(2); push8(2);
        chk("rsth_pre_valid", 32'(b8.out_valid), 1);
        chk("rsth_pre_acc", 32'($signed(b8.out_acc)), 8);
        #2;
        rstn = 1'b0;
        #1;
        chk("rsth_out_valid", 32'(b8.out_valid), 0);
        chk("rsth_in_ready", 32'(b8.in_ready), 1);
        chk("rsth_out_acc", 32'($signed(b8.out_acc)), 0);
        chk("rsth_out_sat", 32'(b8.out_sat), 0);
        rstn = 1'b1;
        push8(1); push8(1); push8(1); push8(1);
        chk("rsth_resume_valid", 32'(b8.out_valid), 1);
        chk("rsth_resume_acc", 32'($signed(b8.out_acc)), 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/signed_sum_accumulator.md
SIGNED_SUM_ACCUMULATOR -- requirements
Module: signed_sum_accumulator

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 4, number of sums per frame; legal range 1..16.
REQ-002 SHALL have parameter ACC_W, default 8, accumulator width in bits; legal range 6..16.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1, synchronous frame abort; discards the partial frame.
REQ-006 SHALL have port in_valid, input, 1, upstream sum valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a sum.
REQ-008 SHALL have port in_sum, input, 5, two's-complement sum from the 4-bit signed adder stage, range -16..+14.
REQ-009 SHALL have port out_valid, output, 1, frame result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port out_acc, output, ACC_W, signed frame total.
REQ-012 SHALL have port out_sat, output, 1, saturation occurred at least once during the frame.

Function
REQ-013 SHALL implement a two-state FSM: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1); in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-014 SHALL accept a sum only when in_valid and in_ready are both 1 at a clock edge (input handshake).
REQ-015 SHALL, on each input handshake, sign-extend in_sum to ACC_W bits and add it to acc.
REQ-016 SHALL clamp the addition result to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) on overflow (ACC_W=8: 127 / -128) and SHALL set sticky sat_flag when clamping occurs.
REQ-017 SHALL keep a sample counter cnt, width ceil(log2(N_SAMPLES+1)), incremented on each input handshake.
REQ-018 SHALL, when the handshake accepts sample number N_SAMPLES, transition ACCUM->HOLD on that edge; out_valid is asserted the following cycle, giving a latency of 1 cycle after the last accepted sum.
REQ-019 SHALL hold out_acc = acc and out_sat = sat_flag stable throughout HOLD until the output handshake.
REQ-020 SHALL, on the output handshake (out_valid and out_ready), clear acc, cnt and sat_flag and transition HOLD->ACCUM; in_ready returns to 1 the next cycle.
REQ-021 SHALL apply backpressure: while in HOLD with out_ready=0, no sums are accepted and the state is unchanged indefinitely.
REQ-022 SHALL drive out_acc and out_sat to 0 while in ACCUM; the values are valid only when out_valid=1.
REQ-023 SHALL, when clr=1 at an edge, clear acc, cnt and sat_flag and force ACCUM, taking priority over any simultaneous input or output handshake; the sum presented on that edge is dropped.
REQ-024 SHALL support N_SAMPLES=1: every accepted sum produces a frame, with out_acc equal to the sign-extended sum.
REQ-025 SHALL keep a saturated acc clamped, while allowing later sums of the opposite sign to move it back into range (saturation is not latched in acc, only in sat_flag).

Reset
REQ-026 SHALL, while rstn=0 (asynchronously), force state=ACCUM, acc=0, cnt=0, sat_flag=0, giving in_ready=1, out_valid=0, out_acc=0, out_sat=0.
REQ-027 SHALL, on reset assertion mid-frame or during HOLD, discard the partial or pending result with no output handshake.
REQ-028 SHALL resume operation on the first rising clk edge after rstn deasserts, with no extra idle cycles.

Verification
REQ-029 SHALL cover the basic frame (N=4, ACC_W=8): sums 3, -2, 7, 1 with out_ready=1 -> out_valid one cycle after the 4th accept, out_acc=9, out_sat=0, in_ready=1 next cycle.
REQ-030 SHALL cover saturation: sums 14, 14, 14, 14, then 14, 14, 14, 14 across N=4 frames and ACC_W=6 -> first frame out_acc=31, out_sat=1; the second frame starts from 0.
REQ-031 SHALL cover negative clamp and recovery: ACC_W=6, sums -16, -16, -16, +14 -> out_acc=-18, out_sat=1.
REQ-032 SHALL cover backpressure: frame complete with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, out_acc stable, no sum lost or counted; accept resumes after the handshake.
REQ-033 SHALL cover clr and reset: clr after 2 accepted sums coincident with in_valid -> next frame totals only the following 4 sums; rstn pulsed low during HOLD -> out_valid drops immediately and all outputs read 0.
REQ-034 SHALL cover N_SAMPLES=1: sum -5 -> out_acc=-5 (ACC_W=8 0xFB) one cycle later; back-to-back sums with out_ready=1 -> one result every 2 cycles.
